router_term_src_fifo: RTL and testbench

- Per-terminal source buffer sitting directly upstream of one router input terminal; one instance per terminal (ROWS*2 + COLUMS*2 instances).
- Accepts packets from the terminal driver and presents them to the router over the pndng/pop handshake. Its outputs drive the router's data_out_i_in[i] and pndng_i_in[i]; it consumes popin[i].
- Also flags protocol faults: overflow, underflow, and a router that leaves a pending packet unserved for too long.

---
 rtl/router_term_src_fifo.sv | 150 +++++++++++++++
 tb/tb_router_term_src_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/router_term_src_fifo.sv
// Per-terminal source FIFO feeding one router input; first-word-fall-through head on data_out/pndng, sticky fault flags.
// Latency: a push into an empty FIFO is visible on the next cycle; after popin the next head appears on the following cycle.
// Backpressure: none toward the driver -- a push while full without a same-cycle pop is dropped and raises ovf. ROUTER_SRC_STATS_EN adds pkts_in/pkts_out.
module router_term_src_fifo #(
    parameter int PCK_SZ      = 40,
    parameter int DEPTH       = 16,
    parameter int TERM_ID     = 0,
    parameter int DST_MSB     = 5,
    parameter int DST_LSB     = 0,
    parameter int STALL_LIMIT = 128
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [PCK_SZ-1:0]          push_data,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [PCK_SZ-1:0]          data_out,
    output logic                       pndng,
    input  logic                       popin,
    output logic                       ovf,
    output logic                       udf,
    output logic                       self_dst,
`ifdef ROUTER_SRC_STATS_EN
    output logic                       stall,
    output logic [31:0]                pkts_in,
    output logic [31:0]                pkts_out
`else
    output logic                       stall
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SW    = ($clog2(STALL_LIMIT + 1) > 8) ? $clog2(STALL_LIMIT + 1) : 8;
    localparam int DST_W = DST_MSB - DST_LSB + 1;

    localparam logic [CW-1:0]    COUNT_FULL = CW'(DEPTH);
    localparam logic [SW-1:0]    STALL_MAX  = SW'(STALL_LIMIT);
    localparam logic [DST_W-1:0] SELF_DST   = DST_W'(TERM_ID);

    logic [PCK_SZ-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_nxt;
    logic [SW-1:0]     stall_cnt;
    logic [SW-1:0]     stall_cnt_nxt;
    logic              empty;
    logic              push_ok;
    logic              pop_ok;
    logic              is_self;

    assign empty   = (count == '0);
    // Full FIFO still takes a push when the router pops in the same cycle.
    assign pop_ok  = popin && !empty;
    assign push_ok = push && (!full || popin);
    assign is_self = (push_data[DST_MSB:DST_LSB] == SELF_DST);

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        stall_cnt_nxt = stall_cnt;
        if (!pndng || popin) begin
            stall_cnt_nxt = '0;
        end else if (stall_cnt != STALL_MAX) begin
            stall_cnt_nxt = stall_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            pndng     <= 1'b0;
            stall_cnt <= '0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
            self_dst  <= 1'b0;
            stall     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count     <= count_nxt;
            full      <= (count_nxt == COUNT_FULL);
            pndng     <= (count_nxt != '0);
            stall_cnt <= stall_cnt_nxt;
            if (push && full && !popin) begin
                ovf <= 1'b1;
            end
            if (popin && empty) begin
                udf <= 1'b1;
            end
            if (push_ok && is_self) begin
                self_dst <= 1'b1;
            end
            if (stall_cnt_nxt == STALL_MAX) begin
                stall <= 1'b1;
            end
        end
    end

    // Gating with pndng keeps data_out at zero while empty and through reset.
    assign data_out = pndng ? mem[rd_ptr] : '0;

`ifdef ROUTER_SRC_STATS_EN
    logic [31:0] stats_diff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkts_in  <= '0;
            pkts_out <= '0;
        end else begin
            if (push_ok) begin
                pkts_in <= pkts_in + 32'd1;
            end
            if (pop_ok) begin
                pkts_out <= pkts_out + 32'd1;
            end
        end
    end

    assign stats_diff = pkts_in - pkts_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (32'(count) == (stats_diff % 32'(DEPTH + 1)));
        end
    end
`endif

endmodule

// File: tb/tb_router_term_src_fifo.sv
// Directed bench for router_term_src_fifo (TERM_ID=5, DEPTH=16, STALL_LIMIT=128).
module tb_router_term_src_fifo;

    logic        clk;
    logic        reset;
    logic        push;
    logic [39:0] push_data;
    logic        full;
    logic [4:0]  count;
    logic [39:0] data_out;
    logic        pndng;
    logic        popin;
    logic        ovf;
    logic        udf;
    logic        self_dst;
    logic        stall;

    int checks   = 0;
    int failures = 0;

    router_term_src_fifo #(
        .PCK_SZ(40), .DEPTH(16), .TERM_ID(5), .DST_MSB(5), .DST_LSB(0), .STALL_LIMIT(128)
    ) dut (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data),
        .full(full), .count(count), .data_out(data_out), .pndng(pndng),
        .popin(popin), .ovf(ovf), .udf(udf), .self_dst(self_dst), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick(1);
    endtask

    initial begin
        reset = 1'b0; push = 1'b0; popin = 1'b0; push_data = '0;
        #12;
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_pndng", pndng, 0);
        check("rst_data", data_out, 0);
        check("rst_flags", {ovf, udf, self_dst, stall}, 0);
        reset = 1'b1;
        tick(1);

        // Single push, then let the router ignore it until the watchdog fires.
        push = 1'b1; push_data = 40'h00_0000_0003;
        tick(1);
        push = 1'b0;
        check("first_pndng", pndng, 1);
        check("first_data", data_out, 40'h3);
        check("first_count", count, 1);
        tick(127);
        check("stall_before", stall, 0);
        tick(1);
        check("stall_at_limit", stall, 1);
        popin = 1'b1;
        tick(1);
        popin = 1'b0;
        check("drain_count", count, 0);
        check("drain_pndng", pndng, 0);

        // Fill to 16, overflow on 17th, drain in order.
        for (int i = 1; i <= 17; i++) begin
            push = 1'b1; push_data = 40'(i);
            tick(1);
            if (i == 16) begin
                check("fill_full", full, 1);
                check("fill_no_ovf", ovf, 0);
            end
        end
        push = 1'b0;
        check("ovf_set", ovf, 1);
        check("ovf_count", count, 16);
        for (int i = 1; i <= 16; i++) begin
            check("drain_order", data_out, 40'(i));
            popin = 1'b1;
            tick(1);
        end
        popin = 1'b0;
        check("drained_pndng", pndng, 0);
        check("drained_count", count, 0);
        check("drained_full", full, 0);

        // Simultaneous push and pop while full.
        rst_pulse();
        for (int i = 1; i <= 16; i++) begin
            push = 1'b1; push_data = 40'(i);
            tick(1);
        end
        push = 1'b1; push_data = 40'hAA; popin = 1'b1;
        tick(1);
        push = 1'b0; popin = 1'b0;
        check("fullpp_count", count, 16);
        check("fullpp_full", full, 1);
        check("fullpp_ovf", ovf, 0);
        for (int i = 2; i <= 16; i++) begin
            check("fullpp_order", data_out, 40'(i));
            popin = 1'b1;
            tick(1);
            popin = 1'b0;
        end
        check("fullpp_last", data_out, 40'hAA);
        popin = 1'b1;
        tick(1);
        popin = 1'b0;
        check("fullpp_empty", pndng, 0);

        // Pop while empty, then push+pop while empty.
        popin = 1'b1;
        tick(1);
        popin = 1'b0;
        check("udf_set", udf, 1);
        check("udf_count", count, 0);
        check("udf_pndng", pndng, 0);
        rst_pulse();
        push = 1'b1; push_data = 40'h7; popin = 1'b1;
        tick(1);
        push = 1'b0; popin = 1'b0;
        check("emptypp_count", count, 1);
        check("emptypp_udf", udf, 1);
        check("emptypp_data", data_out, 40'h7);

        // Destination matching TERM_ID.
        rst_pulse();
        push = 1'b1; push_data = 40'h12_3456_7806;
        tick(1);
        check("dst6_no_self", self_dst, 0);
        push_data = 40'h12_3456_7805;
        tick(1);
        push = 1'b0;
        check("dst5_self", self_dst, 1);
        check("dst_count", count, 2);
        check("dst6_deliver", data_out, 40'h12_3456_7806);
        popin = 1'b1;
        tick(1);
        check("dst5_deliver", data_out, 40'h12_3456_7805);
        tick(1);
        popin = 1'b0;
        check("dst_empty", count, 0);

        // Pointer wrap with continuous push+pop, then reset mid-stream.
        rst_pulse();
        push = 1'b1; push_data = 40'd100;
        tick(1);
        for (int k = 1; k <= 40; k++) begin
            push_data = 40'(100 + k); popin = 1'b1;
            tick(1);
            check("wrap_head", data_out, 40'(100 + k));
        end
        popin = 1'b0; push_data = 40'd141;
        tick(2);
        check("wrap_count", count, 3);
        check("wrap_no_stall", stall, 0);
        check("wrap_no_flags", {ovf, udf}, 0);
        reset = 1'b0;
        #1;
        check("async_pndng", pndng, 0);
        check("async_data", data_out, 0);
        check("async_count", count, 0);
        push = 1'b0;
        #3;
        reset = 1'b1;
        tick(1);
        check("post_rst_count", count, 0);
        check("post_rst_pndng", pndng, 0);
        push = 1'b1; push_data = 40'hDE_ADBE_EF01;
        tick(1);
        push = 1'b0;
        check("post_rst_data", data_out, 40'hDE_ADBE_EF01);
        check("post_rst_cnt1", count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
